monitor_slave_mc: RTL and testbench
===================================

Name: monitor_slave_mc

Overview:
Multi-channel, parametrised successor to the single-channel monitor card.
- Captures NUM_CH monitored DATA_W-bit buses into per-channel ring buffers of DEPTH entries on every enabled step.
- Adds a bus-writable control register with circular vs stop-when-full mode, soft clear and freeze, plus a capture-count register.
- Serves all reads and writes through a CARD_SEL/SACK_N slave handshake on the monitor bus, alongside the card ID, status and the C/D pass-through words.

Parameters:
- DATA_W, 32, width of each monitored channel and of SDO (fixed 32 for bus compatibility; other values are illegal).
- DEPTH, 32, entries per channel; power of 2, 2..64.
- NUM_CH, 2, number of monitored channels, 1..8.
- CARD_ID, 8'h4C, value returned in the ID field.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CARD_SEL  in  1  bus select for this card; held high for the whole transaction.
- AI  in  10  bus address; decoded per the address map.
- WR_IN_N  in  1  0 = write, 1 = read; sampled with the address.
- C_IN  in  32  pass-through word C.
- D_IN  in  32  pass-through word D.
- C_DATA  in  32  bus write data.
- step_en  in  1  step strobe from the processor.
- in_init  in  1  processor in init phase; blocks capture.
- stop_n  in  1  0 = processor halted; blocks capture.
- DIN  in  NUM_CH*DATA_W  monitored buses; channel k occupies DIN[k*DATA_W +: DATA_W].
- SACK_N  out  1  slave acknowledge, active low.
- SDO  out  32  slave read data.
- REG_ADDR  out  5  register-file index for external readout; combinationally equal to AI[4:0].

Behaviour:
- Reset (sync, CLK edge with RESET=1):
  - SACK_N=1, SDO=0, FSM=IDLE.
  - Control register = 0; wr_ptr = 0; count = 0; wrapped = 0.
  - Buffer RAM contents are not reset.
  - Reset mid-transaction aborts it; the write is not committed unless already performed.
- Capture condition: cap = step_en & ~in_init & stop_n & ~freeze & ~(mode & full).
  - On cap, every channel writes its DIN slice at wr_ptr.
  - wr_ptr increments mod DEPTH.
  - count increments, saturating at DEPTH.
  - wrapped is set when wr_ptr wraps to 0 (circular mode only).
  - full = (count == DEPTH).
- Address map:
  - AI[9]=0 selects the buffer: channel = AI[8:6], entry index i = AI[5:0].
    - Oldest-first ordering: physical address = (oldest + i) mod DEPTH, with oldest = wrapped ? wr_ptr : 0.
    - Returns 0 if i >= count or channel >= NUM_CH.
  - AI[9]=1 selects registers by AI[2:0]:
    - 0: STATUS = {16'b0, CARD_ID, 3'b0, stop_n, in_init, freeze, wrapped, full}.
    - 1: C_IN.
    - 2: D_IN.
    - 3: CTRL = {29'b0, freeze, 1'b0, mode}; read/write.
    - 4: {25'b0, count} (7 bits).
    - 5..7: read 0.
- Control register (CTRL) bits:
  - bit0 mode: 0 = circular, 1 = stop-when-full.
  - bit1 clear: self-clearing, never reads as 1. A write with bit1=1 zeroes wr_ptr, count and wrapped in the same edge as the write.
  - bit2 freeze.
- Slave FSM (IDLE -> ADDR -> ACK -> IDLE):
  - IDLE -> ADDR when CARD_SEL=1. AI, WR_IN_N and C_DATA are latched on this edge; the RAM read is issued here.
  - ADDR -> ACK unconditionally:
    - SDO is registered with the selected read data (0 for writes).
    - SACK_N goes to 0.
    - A write to CTRL commits on this edge.
    - Latency: SACK_N low exactly 2 cycles after CARD_SEL is first seen high.
  - ACK holds SDO and SACK_N=0 while CARD_SEL=1.
  - ACK -> IDLE when CARD_SEL=0; on that edge SACK_N=1 and SDO=0.
  - CARD_SEL dropping while in ADDR: still go to ACK for one cycle, then IDLE.
  - Writes to read-only or buffer addresses are ignored but still acknowledged.
- Simultaneous events:
  - Capture and buffer read of the same physical entry in the same cycle: the read returns the old data (read-before-write).
  - Clear and cap in the same cycle: clear wins and the sample is dropped.
  - CTRL write setting freeze and cap in the same cycle: the sample is captured (freeze takes effect on the next cycle).
  - A count/full update and a read of STATUS or count in the same cycle: the read returns the pre-update value.

Decomposition:
- monitor_pkg holds:
  - region bit and register offsets (REG_STATUS=0, REG_C=1, REG_D=2, REG_CTRL=3, REG_COUNT=4);
  - STATUS/CTRL bit positions;
  - the slave FSM state enum.
- Sub-module la_ring_buffer (params DATA_W, DEPTH, NUM_CH):
  - contains the RAM array, wr_ptr, count and wrapped logic;
  - has a synchronous read port;
  - top module contains the FSM, decode and CTRL register.

Test Plan:
- Reset, then read STATUS (AI=10'h200) -> SACK_N low at cycle 2 after CARD_SEL, SDO=32'h00004C10 with stop_n=1, in_init=0.
- 5 steps with ch0=i, ch1=100+i (i=0..4), then read AI=10'h043 -> SDO=103. Read count -> 5. Read entry 5 -> 0.
- Circular mode, DEPTH+3 steps with ch0=i, then read entry 0 of ch0 -> 3; read entry DEPTH-1 -> DEPTH+2; STATUS wrapped=1, full=1.
- Write CTRL=1 (stop-when-full), then DEPTH+5 steps -> count=DEPTH, entry DEPTH-1 = DEPTH-1, wrapped=0.
- Write CTRL=2 on the same cycle step_en=1 -> count=0 afterwards and CTRL reads 0; with in_init=1 or stop_n=0, steps do not capture.
- Assert RESET while in ACK -> next cycle SACK_N=1, SDO=0; CARD_SEL still high -> a new transaction starts.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared constants and types for the multi-channel monitor card:
// address map offsets, STATUS/CTRL bit positions and the slave FSM states.
package monitor_pkg;

  localparam int REGION_BIT = 9;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_C      = 3'd1;
  localparam logic [2:0] REG_D      = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;

  localparam int ST_FULL    = 0;
  localparam int ST_WRAPPED = 1;
  localparam int ST_FREEZE  = 2;
  localparam int ST_INIT    = 3;
  localparam int ST_STOPN   = 4;
  localparam int ST_ID_LSB  = 8;

  localparam int CTRL_MODE   = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_FREEZE = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_ACK  = 2'd2
  } slave_state_t;

  // Assembles the STATUS word from the live card flags.
  function automatic logic [31:0] packStatus(input logic [7:0] id,
                                             input logic stopN,
                                             input logic inInit,
                                             input logic freeze,
                                             input logic wrapped,
                                             input logic full);
    logic [31:0] status;
    status                     = '0;
    status[ST_ID_LSB +: 8]     = id;
    status[ST_STOPN]           = stopN;
    status[ST_INIT]            = inInit;
    status[ST_FREEZE]          = freeze;
    status[ST_WRAPPED]         = wrapped;
    status[ST_FULL]            = full;
    return status;
  endfunction

endpackage

// File: rtl/la_ring_buffer.sv
// Per-channel capture RAM with shared write pointer, saturating count and wrap flag.
// The read port is synchronous and returns entries oldest-first.
module la_ring_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_CH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_cap,
  input  logic                       i_clear,
  input  logic                       i_mode,
  input  logic [NUM_CH*DATA_W-1:0]   i_din,
  input  logic                       i_rd_en,
  input  logic [2:0]                 i_rd_ch,
  input  logic [5:0]                 i_rd_idx,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_wrapped,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] r_rd_word [NUM_CH];
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_wrapped;
  logic [2:0]        r_rd_ch;
  logic              r_rd_valid;

  logic [AW-1:0]     w_oldest;
  logic [AW-1:0]     w_phys;
  logic              w_rd_valid;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_wrapped = r_wrapped;

  assign w_oldest   = r_wrapped ? r_wr_ptr : '0;
  assign w_phys     = w_oldest + i_rd_idx[AW-1:0];
  assign w_rd_valid = (int'(i_rd_idx) < int'(r_count)) && (int'(i_rd_ch) < NUM_CH);

  // Clear has priority over capture so a simultaneous sample is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_cap) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (!o_full) begin
        r_count <= r_count + CW'(1);
      end
      if (!i_mode && (r_wr_ptr == AW'(DEPTH - 1))) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  // Each channel RAM has one write and one read port; reads see pre-write data.
  always_ff @(posedge i_clk) begin
    if (i_cap && !i_clear) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_mem[k][r_wr_ptr] <= i_din[k*DATA_W +: DATA_W];
      end
    end
    if (i_rd_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_rd_word[k] <= r_mem[k][w_phys];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ch    <= '0;
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_ch    <= i_rd_ch;
      r_rd_valid <= w_rd_valid;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_rd_valid && (r_rd_ch == 3'(k))) begin
        o_rd_data = r_rd_word[k];
      end
    end
  end

endmodule

// File: rtl/monitor_slave_mc.sv
// Multi-channel monitor card: capture gating, CTRL register and the
// CARD_SEL/SACK_N slave FSM serving buffer and register reads.
module monitor_slave_mc
  import monitor_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 32,
  parameter int          NUM_CH  = 2,
  parameter logic [7:0]  CARD_ID = 8'h4C
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CARD_SEL,
  input  logic [9:0]                AI,
  input  logic                      WR_IN_N,
  input  logic [31:0]               C_IN,
  input  logic [31:0]               D_IN,
  input  logic [31:0]               C_DATA,
  input  logic                      step_en,
  input  logic                      in_init,
  input  logic                      stop_n,
  input  logic [NUM_CH*DATA_W-1:0]  DIN,
  output logic                      SACK_N,
  output logic [31:0]               SDO,
  output logic [4:0]                REG_ADDR
);

  localparam int CW = $clog2(DEPTH) + 1;

  slave_state_t      r_state;
  logic              r_region;
  logic              r_wr;
  logic [2:0]        r_reg_sel;
  logic [2:0]        r_wdata;
  logic              r_mode;
  logic              r_freeze;

  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_wrapped;
  logic              w_cap;
  logic              w_ctrl_wr;
  logic              w_clear;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_buf_data;
  logic [31:0]       w_rd_data;
  logic              w_unused_cdata;

  assign REG_ADDR       = AI[4:0];
  assign w_unused_cdata = ^C_DATA[31:3];

  assign w_cap     = step_en & ~in_init & stop_n & ~r_freeze & ~(r_mode & w_full);
  assign w_ctrl_wr = (r_state == S_ADDR) && r_wr && r_region && (r_reg_sel == REG_CTRL);
  assign w_clear   = w_ctrl_wr && r_wdata[CTRL_CLEAR];
  assign w_rd_en   = (r_state == S_IDLE) && CARD_SEL;

  la_ring_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH)
  ) u_ring (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_cap     (w_cap),
    .i_clear   (w_clear),
    .i_mode    (r_mode),
    .i_din     (DIN),
    .i_rd_en   (w_rd_en),
    .i_rd_ch   (AI[8:6]),
    .i_rd_idx  (AI[5:0]),
    .o_rd_data (w_buf_data),
    .o_count   (w_count),
    .o_wrapped (w_wrapped),
    .o_full    (w_full)
  );

  // Mode/freeze change on the ADDR->ACK edge, so a capture on that edge still uses the old values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mode   <= 1'b0;
      r_freeze <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_mode   <= r_wdata[CTRL_MODE];
      r_freeze <= r_wdata[CTRL_FREEZE];
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (!r_wr) begin
      if (!r_region) begin
        w_rd_data = 32'(w_buf_data);
      end else begin
        case (r_reg_sel)
          REG_STATUS: w_rd_data = packStatus(CARD_ID, stop_n, in_init, r_freeze, w_wrapped, w_full);
          REG_C:      w_rd_data = C_IN;
          REG_D:      w_rd_data = D_IN;
          REG_CTRL:   w_rd_data = {29'b0, r_freeze, 1'b0, r_mode};
          REG_COUNT:  w_rd_data = {25'b0, 7'(w_count)};
          default:    w_rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      SACK_N    <= 1'b1;
      SDO       <= '0;
      r_region  <= 1'b0;
      r_wr      <= 1'b0;
      r_reg_sel <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CARD_SEL) begin
            r_region  <= AI[REGION_BIT];
            r_reg_sel <= AI[2:0];
            r_wr      <= ~WR_IN_N;
            r_wdata   <= C_DATA[2:0];
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          SDO     <= w_rd_data;
          SACK_N  <= 1'b0;
          r_state <= S_ACK;
        end
        S_ACK: begin
          if (!CARD_SEL) begin
            SACK_N  <= 1'b1;
            SDO     <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_slave_mc.sv
// Scoreboard bench for monitor_slave_mc: bus transactions queue their expected
// SDO, and a monitor pops and compares on each falling edge of SACK_N.
module tb_monitor_slave_mc;

  localparam int DEPTH  = 32;
  localparam int NUM_CH = 2;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 CARD_SEL;
  logic [9:0]           AI;
  logic                 WR_IN_N;
  logic [31:0]          C_IN;
  logic [31:0]          D_IN;
  logic [31:0]          C_DATA;
  logic                 step_en;
  logic                 in_init;
  logic                 stop_n;
  logic [NUM_CH*32-1:0] DIN;
  logic                 SACK_N;
  logic [31:0]          SDO;
  logic [4:0]           REG_ADDR;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] expQ[$];
  string       nameQ[$];
  logic        prevSack = 1'b1;

  always #5 CLK = ~CLK;

  monitor_slave_mc #(
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .NUM_CH  (NUM_CH),
    .CARD_ID (8'h4C)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CARD_SEL (CARD_SEL),
    .AI       (AI),
    .WR_IN_N  (WR_IN_N),
    .C_IN     (C_IN),
    .D_IN     (D_IN),
    .C_DATA   (C_DATA),
    .step_en  (step_en),
    .in_init  (in_init),
    .stop_n   (stop_n),
    .DIN      (DIN),
    .SACK_N   (SACK_N),
    .SDO      (SDO),
    .REG_ADDR (REG_ADDR)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every new acknowledge consumes one scoreboard entry.
  always @(negedge CLK) begin : monitor
    string n;
    if (prevSack === 1'b1 && SACK_N === 1'b0) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_ack: got SDO 0x%08h, expected no acknowledge", SDO);
      end else begin
        n = nameQ.pop_front();
        checkOutput(n, SDO, expQ.pop_front());
      end
    end
    prevSack = SACK_N;
  end

  // One complete bus transaction; writes are expected to return SDO=0.
  task automatic applyStimulus(input logic [9:0] addr, input bit isWrite, input logic [31:0] wdata,
                               input logic [31:0] expected, input string name, input bit holdStep = 1'b0);
    int cycles = 0;
    @(negedge CLK);
    AI       = addr;
    WR_IN_N  = !isWrite;
    C_DATA   = wdata;
    CARD_SEL = 1'b1;
    if (holdStep) step_en = 1'b1;
    expQ.push_back(isWrite ? 32'h0 : expected);
    nameQ.push_back(name);
    do begin
      @(posedge CLK); #1;
      cycles++;
    end while (SACK_N !== 1'b0 && cycles < 8);
    checkOutput({name, "_latency"}, 32'(cycles), 32'd2);
    @(negedge CLK);
    CARD_SEL = 1'b0;
    step_en  = 1'b0;
    @(posedge CLK); #1;
    checkOutput({name, "_release_sack"}, {31'b0, SACK_N}, 32'd1);
    checkOutput({name, "_release_sdo"}, SDO, 32'd0);
  endtask

  task automatic doSteps(input int n, input logic [31:0] base0, input logic [31:0] base1);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      step_en = 1'b1;
      DIN     = {base1 + 32'(i), base0 + 32'(i)};
    end
    @(negedge CLK);
    step_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    RESET    = 1'b1;
    CARD_SEL = 1'b0;
    AI       = '0;
    WR_IN_N  = 1'b1;
    C_IN     = 32'hC0C0_1234;
    D_IN     = 32'hD0D0_5678;
    C_DATA   = '0;
    step_en  = 1'b0;
    in_init  = 1'b0;
    stop_n   = 1'b1;
    DIN      = '0;

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_sack", {31'b0, SACK_N}, 32'd1);
    checkOutput("reset_sdo", SDO, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    AI    = 10'h21D;
    #1;
    checkOutput("reg_addr", {27'b0, REG_ADDR}, 32'h1D);

    applyStimulus(10'h200, 0, 0, 32'h0000_4C10, "status_reset");

    doSteps(5, 32'd0, 32'd100);
    applyStimulus(10'h043, 0, 0, 32'd103, "ch1_entry3");
    applyStimulus(10'h204, 0, 0, 32'd5, "count5");
    applyStimulus(10'h005, 0, 0, 32'd0, "entry5_empty");
    applyStimulus(10'h004, 0, 0, 32'd4, "ch0_entry4");
    applyStimulus(10'h080, 0, 0, 32'd0, "bad_channel");
    applyStimulus(10'h201, 0, 0, 32'hC0C0_1234, "c_word");
    applyStimulus(10'h202, 0, 0, 32'hD0D0_5678, "d_word");
    applyStimulus(10'h205, 0, 0, 32'd0, "reg5");
    applyStimulus(10'h201, 1, 32'hFFFF_FFFF, 32'd0, "write_readonly");
    applyStimulus(10'h203, 0, 0, 32'd0, "ctrl_untouched");

    // Circular mode overrun by three samples.
    applyStimulus(10'h203, 1, 32'd2, 32'd0, "ctrl_clear1");
    doSteps(DEPTH + 3, 32'd0, 32'h1000);
    applyStimulus(10'h000, 0, 0, 32'd3, "circ_oldest");
    applyStimulus(10'h01F, 0, 0, 32'(DEPTH + 2), "circ_newest");
    applyStimulus(10'h040, 0, 0, 32'h1003, "circ_ch1_oldest");
    applyStimulus(10'h200, 0, 0, 32'h0000_4C13, "circ_status");
    applyStimulus(10'h204, 0, 0, 32'(DEPTH), "circ_count");

    // Stop-when-full, entered together with a clear.
    applyStimulus(10'h203, 1, 32'd3, 32'd0, "ctrl_stop_clear");
    applyStimulus(10'h203, 0, 0, 32'd1, "ctrl_read_mode");
    doSteps(DEPTH + 5, 32'd0, 32'd0);
    applyStimulus(10'h204, 0, 0, 32'(DEPTH), "stop_count");
    applyStimulus(10'h01F, 0, 0, 32'(DEPTH - 1), "stop_last");
    applyStimulus(10'h000, 0, 0, 32'd0, "stop_first");
    applyStimulus(10'h200, 0, 0, 32'h0000_4C11, "stop_status");

    // Clear racing a capture: the clear wins.
    applyStimulus(10'h203, 1, 32'd0, 32'd0, "ctrl_circular");
    DIN = {32'hEE, 32'hEE};
    applyStimulus(10'h203, 1, 32'd2, 32'd0, "clear_with_step", 1'b1);
    applyStimulus(10'h204, 0, 0, 32'd0, "clear_count");
    applyStimulus(10'h203, 0, 0, 32'd0, "clear_ctrl_reads0");
    applyStimulus(10'h200, 0, 0, 32'h0000_4C10, "clear_status");

    in_init = 1'b1;
    doSteps(3, 32'd1, 32'd1);
    applyStimulus(10'h200, 0, 0, 32'h0000_4C18, "init_status");
    applyStimulus(10'h204, 0, 0, 32'd0, "init_count");
    in_init = 1'b0;
    stop_n  = 1'b0;
    doSteps(3, 32'd1, 32'd1);
    applyStimulus(10'h200, 0, 0, 32'h0000_4C00, "halt_status");
    applyStimulus(10'h204, 0, 0, 32'd0, "halt_count");
    stop_n = 1'b1;

    // Freeze written during steps: both transaction edges still capture.
    DIN = {32'hAA, 32'h55};
    applyStimulus(10'h203, 1, 32'd4, 32'd0, "freeze_with_step", 1'b1);
    applyStimulus(10'h204, 0, 0, 32'd2, "freeze_count");
    applyStimulus(10'h203, 0, 0, 32'd4, "freeze_ctrl");
    doSteps(3, 32'h99, 32'h99);
    applyStimulus(10'h204, 0, 0, 32'd2, "frozen_count");
    applyStimulus(10'h200, 0, 0, 32'h0000_4C14, "frozen_status");
    applyStimulus(10'h203, 1, 32'd0, 32'd0, "unfreeze");
    doSteps(1, 32'h77, 32'h88);
    applyStimulus(10'h204, 0, 0, 32'd3, "unfrozen_count");
    applyStimulus(10'h000, 0, 0, 32'h55, "unfrozen_e0");
    applyStimulus(10'h002, 0, 0, 32'h77, "unfrozen_e2");
    applyStimulus(10'h041, 0, 0, 32'hAA, "unfrozen_ch1_e1");

    // Reset while acknowledging, with CARD_SEL held high throughout.
    @(negedge CLK);
    AI       = 10'h200;
    WR_IN_N  = 1'b1;
    CARD_SEL = 1'b1;
    expQ.push_back(32'h0000_4C10);
    nameQ.push_back("status_pre_reset");
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("pre_reset_sack", {31'b0, SACK_N}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    checkOutput("rst_in_ack_sack", {31'b0, SACK_N}, 32'd1);
    checkOutput("rst_in_ack_sdo", SDO, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    expQ.push_back(32'h0000_4C10);
    nameQ.push_back("status_post_reset");
    cycles = 0;
    do begin
      @(posedge CLK); #1;
      cycles++;
    end while (SACK_N !== 1'b0 && cycles < 8);
    checkOutput("post_reset_latency", 32'(cycles), 32'd2);
    @(negedge CLK);
    CARD_SEL = 1'b0;
    @(posedge CLK); #1;
    checkOutput("post_reset_release", {31'b0, SACK_N}, 32'd1);
    applyStimulus(10'h204, 0, 0, 32'd0, "count_after_reset");

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
